ps2_host_tx: RTL and testbench

//   Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the

---
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit/request-to-send, shifts one command byte on
// device clock falls, checks the device ACK and aborts if the device stops clocking.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t             r_state;
  logic               r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic               r_clk_filt, r_clk_filt_d;
  logic [FLT_W-1:0]   r_flt_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [9:0]         r_shift;
  logic [3:0]         r_bit;
  logic               r_ack_err;
  logic               w_fall;
  logic               w_timed;
  logic               w_timeout;

  // Stage: pin synchronizers and ps2_clk glitch filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_flt_cnt    <= '0;
    end else begin
      r_clk_s1     <= ps2_clk_in;
      r_clk_s2     <= r_clk_s1;
      r_dat_s1     <= ps2_data_in;
      r_dat_s2     <= r_dat_s1;
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_s2;
        r_flt_cnt  <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  assign w_fall    = r_clk_filt_d & ~r_clk_filt;
  assign w_timed   = (r_state == S_REQ) || (r_state == S_SHIFT) ||
                     (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stage: transfer FSM with registered pin drives and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_bit       <= '0;
      r_ack_err   <= 1'b0;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (w_timed && w_timeout) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_done     <= 1'b1;
        tx_error    <= 1'b1;
        busy        <= 1'b0;
        tx_ready    <= 1'b1;
        r_cnt       <= '0;
        r_bit       <= '0;
        r_state     <= S_IDLE;
      end else begin
        // Device clock activity keeps the watchdog from expiring.
        if (w_timed) r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
        case (r_state)
          S_IDLE: begin
            if (tx_valid) begin
              r_shift    <= {1'b1, ~^tx_data, tx_data};
              r_bit      <= '0;
              r_cnt      <= '0;
              busy       <= 1'b1;
              tx_ready   <= 1'b0;
              ps2_clk_oe <= 1'b1;
              r_state    <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
              ps2_data_oe <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_REQ;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_REQ: begin
            ps2_clk_oe <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_SHIFT;
          end
          S_SHIFT: begin
            if (w_fall) begin
              ps2_data_oe <= ~r_shift[0];
              r_shift     <= {1'b0, r_shift[9:1]};
              if (r_bit == 4'd9) begin
                r_bit   <= '0;
                r_state <= S_ACK;
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
          end
          S_ACK: begin
            if (w_fall) begin
              r_ack_err <= r_dat_s2;
              r_state   <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (r_clk_s2 && r_dat_s2) begin
              tx_done  <= 1'b1;
              tx_error <= r_ack_err;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a PS/2 device model that clocks frames,
// samples host data on rising edges and returns ACK/NACK.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 300;
  localparam int FLT = 4;
  localparam int H   = 25;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       dev_clk = 1'b1;
  logic       dev_data_low = 1'b0;
  logic       line_clk, line_data;

  assign line_clk  = dev_clk & ~ps2_clk_oe;
  assign line_data = ~dev_data_low & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(line_clk), .ps2_data_in(line_data), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int oe_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (ps2_clk_oe) oe_cnt++;
    if (tx_done) done_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       nack;
    logic       glitch;
    logic       hold;
    logic [9:0] frame;
    logic       err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int base_oe;

  task automatic start_tx(input logic [7:0] d, input logic hold);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_before_send", int'(tx_ready), 1);
    base_oe  = oe_cnt;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (hold) tx_data = 8'h55;
    else tx_valid = 1'b0;
  endtask

  task automatic wait_release();
    int n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < INH + 50) begin
      @(negedge clk); n++;
    end
    chk("request_to_send", int'(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1), 1);
  endtask

  task automatic dev_clock(input logic nack, input logic glitch, input int nedges,
                           output logic [9:0] got);
    got = '0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nedges; i++) begin
      if (i == 10) begin
        dev_data_low = ~nack;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) got[i] = line_data;
      if (i == 10) begin
        dev_data_low = 1'b0;
      end else if (glitch && i == 4) begin
        repeat (8) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H - 10) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input int limit, output logic seen, output logic err);
    seen = 1'b0;
    err  = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1;
        err  = tx_error;
        tx_valid = 1'b0;
        break;
      end
    end
  endtask

  vec_t       vec [5];
  logic [9:0] got;
  logic       seen, err;
  int         base_done, n;

  initial begin
    vec[0] = '{8'hED, 1'b0, 1'b0, 1'b0, 10'h3ED, 1'b0};
    vec[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 10'h300, 1'b1};
    vec[2] = '{8'hF4, 1'b0, 1'b0, 1'b1, 10'h2F4, 1'b0};
    vec[3] = '{8'hED, 1'b0, 1'b1, 1'b0, 10'h3ED, 1'b0};
    vec[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10'h3A5, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("rst_done", int'({tx_done, tx_error}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Device never clocks: watchdog abort
    base_done = done_cnt;
    start_tx(8'hFF, 1'b0);
    wait_release();
    n = 0;
    while (!tx_done && n < TMO + 50) begin @(negedge clk); n++; end
    chk("timeout_cycles", n, TMO);
    chk("timeout_done", int'(tx_done), 1);
    chk("timeout_error", int'(tx_error), 1);
    chk("timeout_pins", int'({ps2_clk_oe, ps2_data_oe}), 0);
    repeat (5) @(negedge clk);
    chk("timeout_ready", int'(tx_ready), 1);
    chk("timeout_one_done", done_cnt - base_done, 1);

    // Asynchronous reset while bit 4 (a 0 of 0xED) is being driven
    base_done = done_cnt;
    start_tx(8'hED, 1'b0);
    wait_release();
    dev_clock(1'b0, 1'b0, 4, got);
    chk("pre_reset_bits", int'(got[3:0]), 4'hD);
    dev_clk = 1'b0;
    repeat (12) @(negedge clk);
    chk("bit4_driven_low", int'(ps2_data_oe), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_pins", int'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("reset_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(busy), 0);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("reset_no_done", done_cnt - base_done, 0);

    for (int v = 0; v < 5; v++) begin
      base_done = done_cnt;
      start_tx(vec[v].data, vec[v].hold);
      wait_release();
      chk($sformatf("v%0d_clk_oe_cycles", v), oe_cnt - base_oe, INH + 1);
      chk($sformatf("v%0d_busy", v), int'(busy), 1);
      dev_clock(vec[v].nack, vec[v].glitch, 11, got);
      wait_done(200, seen, err);
      chk($sformatf("v%0d_frame", v), int'(got), int'(vec[v].frame));
      chk($sformatf("v%0d_done", v), int'(seen), 1);
      chk($sformatf("v%0d_error", v), int'(err), int'(vec[v].err));
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_one_done", v), done_cnt - base_done, 1);
      chk($sformatf("v%0d_idle", v), int'({tx_ready, busy}), 2);
      chk($sformatf("v%0d_pins", v), int'({ps2_clk_oe, ps2_data_oe}), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
